// File: rtl/wb_arbiter_if.sv
// Bus bundle for the register-file write arbiter: pipeline and long-latency
// result inputs, the write port, and the hazard/flow-control status outputs.
interface wb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             pipe_valid;
    logic [4:0]       pipe_rd;
    logic [WIDTH-1:0] pipe_data;
    logic             lu_valid;
    logic [4:0]       lu_rd;
    logic [WIDTH-1:0] lu_data;
    logic             lu_ready;
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic [31:0]      pending;
    logic [CW-1:0]    fifo_count;
    logic             stall_req;

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        output lu_ready, we, wa, wd, pending, fifo_count, stall_req
    );

    modport master (
        output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        input  lu_ready, we, wa, wd, pending, fifo_count, stall_req
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write arbiter: the in-order pipeline has priority, long-latency
// results wait in a FIFO, and a starvation counter asks upstream for a stall.
module wb_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int STARVE = 8
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int AGEW = $clog2(STARVE + 1);

    logic [4:0]       rdMem_q   [DEPTH];
    logic [WIDTH-1:0] dataMem_q [DEPTH];

    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AGEW-1:0]  age_q, age_d;
    logic             stall_q, stall_d;
    logic             we_q, we_d;
    logic [4:0]       wa_q, wa_d;
    logic [WIDTH-1:0] wd_q, wd_d;

    logic             luReady;
    logic             pipeSel;
    logic             popEn;
    logic             pushEn;
    logic [31:0]      pendingVec;
    logic [AW-1:0]    offset;

    // Occupancy comes only from registered state, so a pop cannot open a slot the same cycle.
    assign luReady = (count_q < CW'(DEPTH));
    assign pipeSel = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    assign popEn   = !pipeSel && (count_q != '0);
    assign pushEn  = bus.lu_valid && luReady && (bus.lu_rd != 5'd0);

    always_comb begin
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        age_d   = age_q;

        if (pipeSel) begin
            we_d = 1'b1;
            wa_d = bus.pipe_rd;
            wd_d = bus.pipe_data;
        end else if (popEn) begin
            we_d    = 1'b1;
            wa_d    = rdMem_q[rdPtr_q];
            wd_d    = dataMem_q[rdPtr_q];
            rdPtr_d = rdPtr_q + AW'(1);
        end

        if (pushEn) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end

        if (pushEn && !popEn) begin
            count_d = count_q + CW'(1);
        end else if (popEn && !pushEn) begin
            count_d = count_q - CW'(1);
        end

        if ((count_q == '0) || popEn) begin
            age_d = '0;
        end else if (age_q < AGEW'(STARVE)) begin
            age_d = age_q + AGEW'(1);
        end

        stall_d = (age_d == AGEW'(STARVE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            age_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            age_q   <= age_d;
            stall_q <= stall_d;
        end
    end

    // Entry storage needs no reset: validity is defined purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            rdMem_q[wrPtr_q]   <= bus.lu_rd;
            dataMem_q[wrPtr_q] <= bus.lu_data;
        end
    end

    always_comb begin
        pendingVec = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rdPtr_q;
            if ({1'b0, offset} < count_q) begin
                pendingVec[rdMem_q[i]] = 1'b1;
            end
        end
    end

    assign bus.lu_ready   = luReady;
    assign bus.we         = we_q;
    assign bus.wa         = wa_q;
    assign bus.wd         = wd_q;
    assign bus.pending    = pendingVec;
    assign bus.fifo_count = count_q;
    assign bus.stall_req  = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_wb_arbiter;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          count;
        logic [31:0] pend;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    vec_t        vecs [8];
    entry_t      q [$];
    logic        mWe;
    logic [4:0]  mWa;
    logic [31:0] mWd;
    int          blocked;
    int          checks = 0;
    int          errors = 0;

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelPending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic modelReset();
        q.delete();
        mWe     = 1'b0;
        mWa     = '0;
        mWd     = '0;
        blocked = 0;
    endtask

    // The model decides from the pre-edge queue, then the edge is taken.
    task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        int     sizeBefore;
        bit     pipeSel, pop, push;
        entry_t e;
        bus.pipe_valid = pv;
        bus.pipe_rd    = prd;
        bus.pipe_data  = pd;
        bus.lu_valid   = lv;
        bus.lu_rd      = lrd;
        bus.lu_data    = ld;
        sizeBefore = q.size();
        pipeSel = pv && (prd != 0);
        pop     = !pipeSel && (sizeBefore > 0);
        push    = lv && (sizeBefore < DEPTH) && (lrd != 0);
        if (pipeSel) begin
            mWe = 1'b1; mWa = prd; mWd = pd;
        end else if (pop) begin
            e = q.pop_front();
            mWe = 1'b1; mWa = e.rd; mWd = e.data;
        end else begin
            mWe = 1'b0;
        end
        if (push) q.push_back('{lrd, ld});
        if (sizeBefore > 0 && !pop) blocked = (blocked < STARVE) ? blocked + 1 : STARVE;
        else blocked = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compareVal({tag, ".we"},         32'(bus.we),         32'(mWe));
        compareVal({tag, ".wa"},         32'(bus.wa),         32'(mWa));
        compareVal({tag, ".wd"},         bus.wd,              mWd);
        compareVal({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(q.size()));
        compareVal({tag, ".pending"},    bus.pending,         modelPending());
        compareVal({tag, ".stall_req"},  32'(bus.stall_req),  32'(blocked == STARVE));
        compareVal({tag, ".lu_ready"},   32'(bus.lu_ready),   32'(q.size() < DEPTH));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        logic        rpv, rlv;
        logic [4:0]  rprd, rlrd;
        int          pvPct;

        vecs[0] = '{1'b1, 5'd5, 32'hA5,   1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hA5, 0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hA5, 0, 32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'h77, 1'b0, 5'd5, 32'hA5, 1, 32'h80};
        vecs[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h77, 0, 32'h0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 32'h77, 0, 32'h0};
        vecs[5] = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd9, 32'h99, 1'b0, 5'd7, 32'h77, 1, 32'h200};
        vecs[6] = '{1'b1, 5'd0, 32'h1,    1'b1, 5'd0, 32'h2,  1'b1, 5'd9, 32'h99, 0, 32'h0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 32'h99, 0, 32'h0};

        bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.lu_valid   = 1'b0; bus.lu_rd   = '0; bus.lu_data   = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        compareVal("reset.lu_ready", 32'(bus.lu_ready), 32'h1);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
            checkOutput($sformatf("vec%0d", i));
            compareVal($sformatf("vec%0d.tbl_we", i),    32'(bus.we),         32'(vecs[i].we));
            compareVal($sformatf("vec%0d.tbl_wa", i),    32'(bus.wa),         32'(vecs[i].wa));
            compareVal($sformatf("vec%0d.tbl_wd", i),    bus.wd,              vecs[i].wd);
            compareVal($sformatf("vec%0d.tbl_count", i), 32'(bus.fifo_count), 32'(vecs[i].count));
            compareVal($sformatf("vec%0d.tbl_pend", i),  bus.pending,         vecs[i].pend);
        end

        // Fill the FIFO behind a busy pipeline until the starvation stall fires, then drain.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'd1, 32'(k), 1'b1, 5'd3, 32'h30 + 32'(k));
            checkOutput($sformatf("fill%0d", k));
        end
        compareVal("full.count", 32'(bus.fifo_count), 32'd4);
        compareVal("full.lu_ready", 32'(bus.lu_ready), 32'd0);
        compareVal("full.pending", bus.pending, 32'h8);
        for (int k = 0; k < STARVE - 3; k++) begin
            applyStimulus(1'b1, 5'd2, 32'h100 + 32'(k), 1'b1, 5'd9, 32'hBAD);
            checkOutput($sformatf("starve%0d", k));
        end
        compareVal("starve.stall", 32'(bus.stall_req), 32'd1);
        compareVal("starve.pipe_wins", 32'(bus.wa), 32'd2);
        for (int k = 0; k < 4; k++) begin
            idle();
            checkOutput($sformatf("drain%0d", k));
            compareVal($sformatf("drain%0d.wa", k), 32'(bus.wa), 32'd3);
            compareVal($sformatf("drain%0d.wd", k), bus.wd, 32'h30 + 32'(k));
            compareVal($sformatf("drain%0d.stall", k), 32'(bus.stall_req), 32'd0);
        end
        idle();
        checkOutput("drained");

        // Hold occupancy at two while pushing and popping every cycle so the pointers wrap.
        applyStimulus(1'b1, 5'd2, 32'h5, 1'b1, 5'd10, 32'h1000);
        checkOutput("wrapfill0");
        applyStimulus(1'b1, 5'd2, 32'h6, 1'b1, 5'd11, 32'h1001);
        checkOutput("wrapfill1");
        for (int k = 0; k < 3 * DEPTH; k++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12 + 5'(k % 8), 32'h2000 + 32'(k));
            checkOutput($sformatf("wrap%0d", k));
            compareVal($sformatf("wrap%0d.count", k), 32'(bus.fifo_count), 32'd2);
        end
        repeat (3) begin
            idle();
            checkOutput("wrapdrain");
        end

        // Queue three entries, then pulse reset between edges.
        applyStimulus(1'b1, 5'd4, 32'hCAFE, 1'b1, 5'd12, 32'hC);
        applyStimulus(1'b1, 5'd4, 32'hCAFE, 1'b1, 5'd13, 32'hD);
        applyStimulus(1'b1, 5'd4, 32'hCAFE, 1'b1, 5'd14, 32'hE);
        checkOutput("prereset");
        bus.pipe_valid = 1'b0;
        bus.lu_valid   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        compareVal("async.we",         32'(bus.we),         32'd0);
        compareVal("async.wa",         32'(bus.wa),         32'd0);
        compareVal("async.wd",         bus.wd,              32'd0);
        compareVal("async.fifo_count", 32'(bus.fifo_count), 32'd0);
        compareVal("async.pending",    bus.pending,         32'd0);
        compareVal("async.stall_req",  32'(bus.stall_req),  32'd0);
        compareVal("async.lu_ready",   32'(bus.lu_ready),   32'd1);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            idle();
            checkOutput("postreset");
        end

        // Randomized traffic with alternating light and heavy pipeline load.
        for (int n = 0; n < 400; n++) begin
            pvPct = ((n / 50) % 2 == 0) ? 35 : 92;
            rpv  = ($urandom_range(0, 99) < pvPct);
            rprd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rlv  = ($urandom_range(0, 99) < 50);
            rlrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(rpv, rprd, $urandom, rlv, rlrd, $urandom);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
